// File: rtl/gpi_event_ctrl_if.sv
// Register-slot bus for gpi_event_ctrl.
//   cs         : slot chip select
//   read       : read strobe, qualified by cs
//   write      : write strobe, qualified by cs
//   addr       : register word address
//   write_data : write data
//   read_data  : combinational read data returned by the slave
// master drives the strobes/address/data; slave returns read_data.
`timescale 1ns/1ps
interface gpi_event_ctrl_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output cs, read, write, addr, write_data,
    input  read_data
  );

  modport slave (
    input  cs, read, write, addr, write_data,
    output read_data
  );
endinterface

// File: rtl/gpi_event_ctrl.sv
// General-purpose input block with debounce, edge detection, sticky
// pending bits and a level interrupt.
//   clk     : sole clock
//   rst     : asynchronous active-low reset
//   bus     : register slot (slave side of gpi_event_ctrl_if)
//   data_in : raw asynchronous input pins
//   irq     : registered level interrupt (irq_en & |PEND)
// Register map (unused bits read 0):
//   0 STABLE RO, 1 PEND W1C, 2 RISE_EN RW, 3 FALL_EN RW,
//   4 DB_LIM RW, 5 CTRL RW (bit0 irq_en)
`timescale 1ns/1ps
module gpi_event_ctrl #(
  parameter int                W          = 4,
  parameter int                DB_W       = 16,
  parameter logic [DB_W-1:0]   DB_DEFAULT = 16'd1000
) (
  input  logic                   clk,
  input  logic                   rst,
  gpi_event_ctrl_if.slave        bus,
  input  logic [W-1:0]           data_in,
  output logic                   irq
);

  logic [W-1:0]    sync1_reg;
  logic [W-1:0]    sync2_reg;
  logic [W-1:0]    stable;
  logic [W-1:0]    rise;
  logic [W-1:0]    fall;
  logic [W-1:0]    pend_reg;
  logic [W-1:0]    pend_next;
  logic [W-1:0]    rise_en_reg;
  logic [W-1:0]    fall_en_reg;
  logic [DB_W-1:0] db_lim_reg;
  logic            irq_en_reg;
  logic            irq_reg;
  logic            wr_en;
  logic [W-1:0]    clr_mask;
  logic [31:0]     read_word;
  logic            unused_wdata;

  assign wr_en = bus.cs & bus.write;

  // Only the low bits of write_data reach registers; keep the rest visibly consumed.
  assign unused_wdata = ^bus.write_data;

  // Two-flop synchronizer for the raw pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= data_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-bit debounce. The counter compares for equality only, so a limit
  // lowered below a running count lets that count wrap around.
  // rise/fall pulse for one cycle, alongside the new stable value.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      logic [DB_W-1:0] cnt_reg;
      logic            stable_bit_reg;
      logic            rise_bit_reg;
      logic            fall_bit_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg        <= '0;
          stable_bit_reg <= 1'b0;
          rise_bit_reg   <= 1'b0;
          fall_bit_reg   <= 1'b0;
        end else begin
          rise_bit_reg <= 1'b0;
          fall_bit_reg <= 1'b0;
          if (sync2_reg[gi] == stable_bit_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == db_lim_reg) begin
            stable_bit_reg <= sync2_reg[gi];
            cnt_reg        <= '0;
            rise_bit_reg   <= sync2_reg[gi];
            fall_bit_reg   <= ~sync2_reg[gi];
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      assign stable[gi] = stable_bit_reg;
      assign rise[gi]   = rise_bit_reg;
      assign fall[gi]   = fall_bit_reg;
    end
  endgenerate

  // W1C clear is applied first, then new events are OR-ed in, so an event
  // landing in the same cycle as its clear survives.
  always_comb begin
    clr_mask = '0;
    if (wr_en && bus.addr == 5'd1) begin
      clr_mask = bus.write_data[W-1:0];
    end
    pend_next = (pend_reg & ~clr_mask) | (rise & rise_en_reg) | (fall & fall_en_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_reg    <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      db_lim_reg  <= DB_DEFAULT;
      irq_en_reg  <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      irq_reg  <= irq_en_reg & (|pend_reg);
      if (wr_en) begin
        case (bus.addr)
          5'd2:    rise_en_reg <= bus.write_data[W-1:0];
          5'd3:    fall_en_reg <= bus.write_data[W-1:0];
          5'd4:    db_lim_reg  <= bus.write_data[DB_W-1:0];
          5'd5:    irq_en_reg  <= bus.write_data[0];
          default: ;
        endcase
      end
    end
  end

  assign irq = irq_reg;

  // Side-effect-free combinational read mux.
  always_comb begin
    read_word = '0;
    if (bus.cs && bus.read) begin
      case (bus.addr)
        5'd0:    read_word[W-1:0]    = stable;
        5'd1:    read_word[W-1:0]    = pend_reg;
        5'd2:    read_word[W-1:0]    = rise_en_reg;
        5'd3:    read_word[W-1:0]    = fall_en_reg;
        5'd4:    read_word[DB_W-1:0] = db_lim_reg;
        5'd5:    read_word[0]        = irq_en_reg;
        default: read_word           = '0;
      endcase
    end
  end

  assign bus.read_data = read_word;

endmodule

// File: tb/tb_gpi_event_ctrl.sv
`timescale 1ns/1ps
module tb_gpi_event_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic       irq;
  logic       irq_probe = 1'b0;
  logic [3:0] stable_model;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  gpi_event_ctrl_if bus();

  gpi_event_ctrl #(
    .W(4),
    .DB_W(16),
    .DB_DEFAULT(16'd1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .data_in(data_in),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: whenever the DUT presents a read (or an irq probe is raised),
  // pop the oldest expectation and compare, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] act;
    logic [31:0] expv;
    string       nm;
    if ((bus.cs && bus.read) || irq_probe) begin
      act = irq_probe ? {31'd0, irq} : bus.read_data;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", act);
      end else begin
        expv = exp_q.pop_front();
        nm   = name_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", nm, act, expv);
        end else begin
          $display("ok   %s value=%h", nm, act);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
    bus.cs   = 1'b1;
    bus.read = 1'b1;
    bus.addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
    bus.cs   = 1'b0;
    bus.read = 1'b0;
  endtask

  task automatic pirq(input logic e, input string nm);
    irq_probe = 1'b1;
    exp_q.push_back({31'd0, e});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
    irq_probe = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs         = 1'b1;
    bus.write      = 1'b1;
    bus.addr       = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.cs    = 1'b0;
    bus.write = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = 5'd0; bus.write_data = 32'd0;

    // Reset values, read while rst is held low.
    tick(2);
    rd(5'd0, 32'h0,   "rst_stable");
    rd(5'd1, 32'h0,   "rst_pend");
    rd(5'd2, 32'h0,   "rst_rise_en");
    rd(5'd3, 32'h0,   "rst_fall_en");
    rd(5'd4, 32'd1000, "rst_db_lim");
    rd(5'd5, 32'h0,   "rst_ctrl");
    pirq(1'b0, "rst_irq");
    tick(1);
    rst = 1'b1;
    tick(2);

    wr(5'd4, 32'd3);
    wr(5'd2, 32'hF);
    wr(5'd5, 32'h1);
    rd(5'd4, 32'd3,  "db_lim_rw");
    rd(5'd2, 32'hF,  "rise_en_rw");
    tick(1);

    // Three-cycle glitch on bit 0 with DB_LIM=3: filtered out.
    data_in = 4'h1;
    tick(3);
    data_in = 4'h0;
    tick(10);
    rd(5'd0, 32'h0, "glitch_stable");
    rd(5'd1, 32'h0, "glitch_pend");
    pirq(1'b0, "glitch_irq");
    tick(1);

    // Held rise on bit 0: STABLE after 6 edges, PEND after 7, irq after 8.
    data_in = 4'h1;
    tick(5);
    rd(5'd0, 32'h0, "rise_stable_early");
    tick(1);
    rd(5'd0, 32'h1, "rise_stable_6");
    tick(1);
    rd(5'd1, 32'h1, "rise_pend_7");
    tick(1);
    pirq(1'b1, "rise_irq_8");
    tick(1);

    // Bring PEND to 3 then W1C it in two steps.
    data_in = 4'h3;
    tick(8);
    rd(5'd1, 32'h3, "pend_3");
    tick(1);
    pirq(1'b1, "pend_3_irq");
    wr(5'd1, 32'h1);
    rd(5'd1, 32'h2, "w1c_bit0");
    tick(1);
    pirq(1'b1, "w1c_bit0_irq");
    wr(5'd1, 32'h2);
    pirq(1'b1, "w1c_all_irq_lag");
    tick(1);
    pirq(1'b0, "w1c_all_irq");
    rd(5'd1, 32'h0, "w1c_all_pend");

    // Fall on bit 2 lands on the same edge as a W1C of bit 2: set wins.
    wr(5'd2, 32'h3);
    wr(5'd3, 32'h4);
    data_in = 4'h7;
    tick(10);
    rd(5'd1, 32'h0, "rise_b2_not_enabled");
    tick(1);
    data_in = 4'h3;
    tick(6);
    wr(5'd1, 32'h4);
    rd(5'd1, 32'h4, "set_beats_clear");
    wr(5'd1, 32'hF);
    rd(5'd1, 32'h0, "pend_cleared");

    // DB_LIM=0: STABLE tracks data_in with 3 cycles of latency.
    wr(5'd2, 32'h0);
    wr(5'd3, 32'h0);
    wr(5'd4, 32'h0);
    stable_model = 4'h3;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] nxt;
      data_in[3] = ~data_in[3];
      nxt = data_in;
      tick(2);
      rd(5'd0, {28'd0, stable_model}, "track_before");
      tick(1);
      rd(5'd0, {28'd0, nxt}, "track_after");
      stable_model = nxt;
      tick(1);
    end
    rd(5'd7, 32'h0, "unmapped_read");
    wr(5'd0, 32'hF);
    rd(5'd0, {28'd0, stable_model}, "ro_write_ignored");

    // Reset mid-debounce with PEND nonzero and irq high.
    wr(5'd2, 32'hF);
    data_in = 4'hB;
    tick(5);
    rd(5'd1, 32'h8, "pre_reset_pend");
    tick(1);
    pirq(1'b1, "pre_reset_irq");
    wr(5'd4, 32'd3);
    data_in = 4'h3;
    tick(3);
    rst = 1'b0;
    #1;
    pirq(1'b0, "mid_reset_irq");
    rd(5'd1, 32'h0,    "mid_reset_pend");
    rd(5'd0, 32'h0,    "mid_reset_stable");
    rd(5'd2, 32'h0,    "mid_reset_rise_en");
    rd(5'd3, 32'h0,    "mid_reset_fall_en");
    rd(5'd4, 32'd1000, "mid_reset_db_lim");
    rd(5'd5, 32'h0,    "mid_reset_ctrl");
    tick(1);
    rst = 1'b1;

    // After reset a held-high pin rises after DB_LIM+1 cycles, no PEND (RISE_EN=0).
    data_in = 4'h1;
    tick(1010);
    rd(5'd0, 32'h1, "post_reset_stable");
    rd(5'd1, 32'h0, "post_reset_pend");
    tick(1);
    pirq(1'b0, "post_reset_irq");

    tick(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpi_event_ctrl.md
GPI_EVENT_CTRL -- requirements
Module: gpi_event_ctrl

Interface
REQ-001 Parameter W, default 4: number of general-purpose input bits.
REQ-002 Parameter DB_W, default 16: width of the debounce limit register and of each per-bit debounce counter.
REQ-003 Parameter DB_DEFAULT, default 16'd1000: reset value of the debounce limit.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-006 cs  input  1  slot chip select.
REQ-007 read  input  1  read strobe, qualified by cs.
REQ-008 write  input  1  write strobe, qualified by cs.
REQ-009 addr  input  5  register word address.
REQ-010 write_data  input  32  write data.
REQ-011 read_data  output  32  read data.
REQ-012 data_in  input  W  raw asynchronous input pins.
REQ-013 irq  output  1  registered level interrupt.

Function
REQ-014 Register map, with unused bits reading 0:
- addr 0 STABLE, RO: debounced value [W-1:0].
- addr 1 PEND, W1C: sticky edge-pending bits [W-1:0].
- addr 2 RISE_EN, RW [W-1:0].
- addr 3 FALL_EN, RW [W-1:0].
- addr 4 DB_LIM, RW [DB_W-1:0].
- addr 5 CTRL, RW: bit0 = irq_en.
REQ-015 A write occurs when cs=1 and write=1 at posedge clk. Writes to RO or unmapped addresses are ignored.
REQ-016 read_data is combinational. It equals the addressed register when cs=1 and read=1, and 0 otherwise or at unmapped addresses. Reads have no side effects.
REQ-017 Each data_in bit passes through a 2-flop synchronizer, giving s[i]. The synchronizer adds 2 cycles of latency.
REQ-018 Each bit has a debounce counter cnt[i] with the following behaviour:
- If s[i]==stable[i]: cnt[i] <= 0.
- Else if cnt[i]==DB_LIM: stable[i] <= s[i] and cnt[i] <= 0.
- Else: cnt[i] <= cnt[i]+1.
REQ-019 Consequence of REQ-018: stable[i] changes on the (DB_LIM+1)-th consecutive cycle with s[i]!=stable[i]. With DB_LIM=0, stable follows s with 1 cycle of latency.
REQ-020 A glitch shorter than DB_LIM+1 cycles at s[i] never changes stable[i].
REQ-021 A DB_LIM write takes effect on the next cycle. If any cnt[i] already exceeds the new DB_LIM, cnt[i] keeps counting and wraps modulo 2^DB_W; there is no compare-greater.
REQ-022 Edge detection:
- rise[i] = stable[i] going 0->1.
- fall[i] = stable[i] going 1->0.
- Both are computed in the same cycle stable updates.
REQ-023 PEND[i] is set on the next posedge after (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
REQ-024 Writing 1 to PEND bit i clears it; writing 0 has no effect.
REQ-025 If a set and a W1C clear of the same bit occur in the same cycle, the set wins and PEND[i] stays 1.
REQ-026 Changing RISE_EN or FALL_EN does not alter existing PEND bits.
REQ-027 irq <= irq_en & |PEND, registered: irq asserts 1 cycle after PEND becomes nonzero and deasserts 1 cycle after PEND becomes zero or irq_en is cleared.
REQ-028 Debounce and edge detection keep running while irq_en=0; PEND still accumulates.

Reset
REQ-029 While rst=0, the following hold immediately and asynchronously:
- synchronizer flops, cnt, STABLE, PEND, RISE_EN, FALL_EN, CTRL and irq are all 0;
- DB_LIM is DB_DEFAULT.
REQ-030 After rst deasserts, a data_in bit held at 1 causes stable[i] to go to 1 per REQ-018. This rise sets PEND only if RISE_EN[i] has been written to 1 by then.
REQ-031 Reset asserted mid-debounce discards the partial count. No edge or pending event is generated by the reset itself.

Verification
REQ-032 DB_LIM=3, RISE_EN=4'hF, CTRL=1; data_in 0->4'h1 held:
- STABLE reads 1 exactly 2+4 cycles after the first sampling edge;
- PEND=1 one cycle later;
- irq=1 one cycle after that.
REQ-033 DB_LIM=3; data_in[0] pulses high for 3 cycles -> STABLE, PEND and irq remain 0.
REQ-034 PEND=4'h3: write 4'h1 to addr 1 -> PEND=4'h2 and irq stays 1. Then write 4'h2 -> PEND=0 and irq=0 one cycle later.
REQ-035 FALL_EN[2]=1; a debounced fall on bit 2 coincides with a W1C write of 4'h4 -> PEND[2]=1 after that edge.
REQ-036 DB_LIM=0; data_in toggles every 4 cycles -> STABLE tracks with 3-cycle latency. Read addr 7 -> 0. Write addr 0 -> STABLE unchanged.
REQ-037 rst pulled low mid-count with PEND nonzero -> all registers at reset values within the same cycle, DB_LIM=DB_DEFAULT and irq=0.
